// File: rtl/game_timer_ctrl.sv
// Countdown game timer (M:SS in BCD) with a two-stage sprite pipeline that overlays the time on video.
// Display path: 1-cycle latency to digit/row/col select, 2-cycle latency to pixel_on/pixel_color; no backpressure.
`timescale 1ns/1ps
module game_timer_ctrl #(
  parameter int unsigned START_MIN      = 3,
  parameter int unsigned START_TENS     = 0,
  parameter int unsigned START_ONES     = 0,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned WARN_SECS      = 10,
  parameter int unsigned X0             = 272,
  parameter int unsigned Y0             = 8,
  parameter logic [8:0]  TRANSPARENT    = 9'd391
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [3:0] digit_code,
  output logic [4:0] sprite_row,
  output logic [4:0] sprite_col,
  input  logic [8:0] sprite_pixel,
  output logic       pixel_on,
  output logic [8:0] pixel_color,
  output logic [3:0] min_d,
  output logic [3:0] tens_d,
  output logic [3:0] ones_d,
  output logic       running,
  output logic       time_up
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [FW-1:0] FRAME_HALF = FW'(FRAMES_PER_SEC / 2);
  localparam logic [3:0] RL_MIN  = 4'(START_MIN);
  localparam logic [3:0] RL_TENS = 4'(START_TENS);
  localparam logic [3:0] RL_ONES = 4'(START_ONES);
  localparam bit RL_ZERO = (START_MIN == 0) && (START_TENS == 0) && (START_ONES == 0);
  localparam logic [9:0] X0_L   = 10'(X0);
  localparam logic [9:0] Y0_L   = 10'(Y0);
  localparam logic [9:0] WARN_L = 10'(WARN_SECS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [3:0]    dig_min_q, dig_min_d;
  logic [3:0]    dig_tens_q, dig_tens_d;
  logic [3:0]    dig_ones_q, dig_ones_d;
  logic          time_up_q, time_up_d;

  logic [3:0]    dec_min, dec_tens, dec_ones;
  logic          cur_zero, dec_zero;
  logic [9:0]    secs_left;
  logic          blank;

  logic          in_area_q, in_area_d;
  logic [3:0]    digit_code_q, digit_code_d;
  logic [4:0]    sprite_row_q, sprite_row_d;
  logic [4:0]    sprite_col_q, sprite_col_d;
  logic          pixel_on_q, pixel_on_d;
  logic [8:0]    pixel_color_q, pixel_color_d;
  logic [9:0]    dx, dy;

  // One-second BCD decrement; saturates at 0:00 so digits stay in range.
  always_comb begin
    cur_zero = (dig_min_q == 4'd0) && (dig_tens_q == 4'd0) && (dig_ones_q == 4'd0);
    dec_min  = dig_min_q;
    dec_tens = dig_tens_q;
    dec_ones = dig_ones_q;
    if (!cur_zero) begin
      if (dig_ones_q != 4'd0) begin
        dec_ones = dig_ones_q - 4'd1;
      end else begin
        dec_ones = 4'd9;
        if (dig_tens_q != 4'd0) begin
          dec_tens = dig_tens_q - 4'd1;
        end else begin
          dec_tens = 4'd5;
          dec_min  = dig_min_q - 4'd1;
        end
      end
    end
    dec_zero = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      dig_min_q  <= RL_MIN;
      dig_tens_q <= RL_TENS;
      dig_ones_q <= RL_ONES;
      time_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      dig_min_q  <= dig_min_d;
      dig_tens_q <= dig_tens_d;
      dig_ones_q <= dig_ones_d;
      time_up_q  <= time_up_d;
    end
  end

  // start beats pause, and pause beats a frame tick arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    dig_min_d  = dig_min_q;
    dig_tens_d = dig_tens_q;
    dig_ones_d = dig_ones_q;
    time_up_d  = 1'b0;
    if (start) begin
      dig_min_d  = RL_MIN;
      dig_tens_d = RL_TENS;
      dig_ones_d = RL_ONES;
      frame_d    = '0;
      if (RL_ZERO) begin
        state_d   = EXPIRED;
        time_up_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (pause && state_q == PAUSED) begin
      state_d = RUN;
    end else if (frame_tick && state_q == RUN) begin
      if (frame_q == FRAME_LAST) begin
        frame_d    = '0;
        dig_min_d  = dec_min;
        dig_tens_d = dec_tens;
        dig_ones_d = dec_ones;
        if (dec_zero) begin
          state_d   = EXPIRED;
          time_up_d = 1'b1;
        end
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_comb begin
    secs_left = 10'(dig_min_q) * 10'd60 + 10'(dig_tens_q) * 10'd10 + 10'(dig_ones_q);
    running   = 1'b0;
    blank     = 1'b0;
    if (state_q == RUN) begin
      running = 1'b1;
      blank   = (secs_left <= WARN_L) && (frame_q >= FRAME_HALF);
    end
  end

  // Stage 1: locate the pixel inside the three 32x24 digit cells.
  always_comb begin
    dx           = DrawX - X0_L;
    dy           = DrawY - Y0_L;
    in_area_d    = (DrawX >= X0_L) && (dx < 10'd96) && (DrawY >= Y0_L) && (dy < 10'd24);
    digit_code_d = 4'd0;
    sprite_row_d = 5'd0;
    sprite_col_d = 5'd0;
    if (in_area_d) begin
      sprite_row_d = dy[4:0];
      sprite_col_d = dx[4:0];
      case (dx[6:5])
        2'd0:    digit_code_d = dig_min_q;
        2'd1:    digit_code_d = dig_tens_q;
        default: digit_code_d = dig_ones_q;
      endcase
    end
  end

  // Stage 2: the sprite mux answers combinationally for the stage-1 selection.
  always_comb begin
    pixel_on_d    = in_area_q && !blank && (sprite_pixel != TRANSPARENT);
    pixel_color_d = pixel_on_d ? sprite_pixel : 9'd0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_area_q     <= 1'b0;
      digit_code_q  <= 4'd0;
      sprite_row_q  <= 5'd0;
      sprite_col_q  <= 5'd0;
      pixel_on_q    <= 1'b0;
      pixel_color_q <= 9'd0;
    end else begin
      in_area_q     <= in_area_d;
      digit_code_q  <= digit_code_d;
      sprite_row_q  <= sprite_row_d;
      sprite_col_q  <= sprite_col_d;
      pixel_on_q    <= pixel_on_d;
      pixel_color_q <= pixel_color_d;
    end
  end

  assign digit_code  = digit_code_q;
  assign sprite_row  = sprite_row_q;
  assign sprite_col  = sprite_col_q;
  assign pixel_on    = pixel_on_q;
  assign pixel_color = pixel_color_q;
  assign min_d       = dig_min_q;
  assign tens_d      = dig_tens_q;
  assign ones_d      = dig_ones_q;
  assign time_up     = time_up_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: seconds-based reference model feeds a scoreboard queue drained by a monitor.
`timescale 1ns/1ps
module tb_game_timer_ctrl;

  localparam int X0 = 272;
  localparam int Y0 = 8;
  localparam int FPS = 60;
  localparam int WARN = 10;
  localparam int RELOAD = 180;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, pause = 1'b0, zstart = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [3:0] digit_code, min_d, tens_d, ones_d;
  logic [4:0] sprite_row, sprite_col;
  logic [8:0] sprite_pixel, pixel_color;
  logic       pixel_on, running, time_up;

  logic [3:0] z_digit_code, z_min, z_tens, z_ones;
  logic [4:0] z_row, z_col;
  logic [8:0] z_color;
  logic       z_pixel_on, z_running, z_time_up;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int spr_mode = 0;

  int m_secs = RELOAD;
  int m_frame = 0;
  int m_mode = M_IDLE;

  typedef struct {
    int due; int kind;
    int mn; int tn; int on; int run; int tu;
    int dc; int row; int col; int pon; int pcol;
  } exp_t;
  exp_t q[$];

  game_timer_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start), .pause(pause),
    .DrawX(DrawX), .DrawY(DrawY), .digit_code(digit_code), .sprite_row(sprite_row),
    .sprite_col(sprite_col), .sprite_pixel(sprite_pixel), .pixel_on(pixel_on),
    .pixel_color(pixel_color), .min_d(min_d), .tens_d(tens_d), .ones_d(ones_d),
    .running(running), .time_up(time_up)
  );

  game_timer_ctrl #(.START_MIN(0), .START_TENS(0), .START_ONES(0)) u_zero (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(zstart), .pause(pause),
    .DrawX(DrawX), .DrawY(DrawY), .digit_code(z_digit_code), .sprite_row(z_row),
    .sprite_col(z_col), .sprite_pixel(9'd0), .pixel_on(z_pixel_on),
    .pixel_color(z_color), .min_d(z_min), .tens_d(z_tens), .ones_d(z_ones),
    .running(z_running), .time_up(z_time_up)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [8:0] spr(input int mode, input int d, input int r, input int c);
    if (mode == 1) return 9'd428;
    if (mode == 2) return 9'd391;
    if ((d + r + c) % 5 == 0) return 9'd391;
    return 9'(d * 40 + r * 3 + c);
  endfunction

  always_comb sprite_pixel = spr(spr_mode, int'(digit_code), int'(sprite_row), int'(sprite_col));

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Drive one cycle of inputs and predict what the DUT shows 1 and 2 cycles later.
  task automatic step(input bit st, input bit pa, input bit tk, input int x, input int y);
    exp_t e0, e1;
    int dig[3];
    bit in_a, blank;
    int dc, row, col, tu, pix;
    start = st; pause = pa; frame_tick = tk;
    DrawX = 10'(x); DrawY = 10'(y);
    in_a = (x >= X0) && (x < X0 + 96) && (y >= Y0) && (y < Y0 + 24);
    dig[0] = m_secs / 60; dig[1] = (m_secs % 60) / 10; dig[2] = m_secs % 10;
    dc  = in_a ? dig[(x - X0) / 32] : 0;
    col = in_a ? (x - X0) % 32 : 0;
    row = in_a ? (y - Y0) : 0;
    tu = 0;
    if (st) begin
      m_secs = RELOAD; m_frame = 0;
      m_mode = (m_secs == 0) ? M_EXP : M_RUN;
      tu = (m_secs == 0) ? 1 : 0;
    end else if (pa && m_mode == M_RUN) begin
      m_mode = M_PAUSED;
    end else if (pa && m_mode == M_PAUSED) begin
      m_mode = M_RUN;
    end else if (tk && m_mode == M_RUN) begin
      m_frame++;
      if (m_frame == FPS) begin
        m_frame = 0;
        m_secs--;
        if (m_secs == 0) begin m_mode = M_EXP; tu = 1; end
      end
    end
    e0 = '{due: cyc + 1, kind: 0, mn: m_secs / 60, tn: (m_secs % 60) / 10, on: m_secs % 10,
           run: (m_mode == M_RUN) ? 1 : 0, tu: tu, dc: dc, row: row, col: col, pon: 0, pcol: 0};
    blank = (m_mode == M_RUN) && (m_secs <= WARN) && (m_frame >= FPS / 2);
    pix = int'(spr(spr_mode, dc, row, col));
    e1 = '{due: cyc + 2, kind: 1, mn: 0, tn: 0, on: 0, run: 0, tu: 0, dc: 0, row: 0, col: 0,
           pon: (in_a && !blank && pix != 391) ? 1 : 0, pcol: 0};
    e1.pcol = (e1.pon != 0) ? pix : 0;
    q.push_back(e0);
    q.push_back(e1);
    @(posedge Clk); #1;
  endtask

  task automatic drain();
    int n;
    start = 0; pause = 0; frame_tick = 0; DrawX = '0; DrawY = '0;
    n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge Clk); n++; end
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(posedge Clk); #1;
  endtask

  task automatic run_to(input int target, input int x, input int y);
    if (m_mode == M_PAUSED) step(0, 1, 0, x, y);
    while (m_secs != target && m_mode == M_RUN) step(0, 0, 1, x, y);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          chk("late_entry", cyc, e.due);
        end else if (e.kind == 0) begin
          chk("min_d", int'(min_d), e.mn);
          chk("tens_d", int'(tens_d), e.tn);
          chk("ones_d", int'(ones_d), e.on);
          chk("running", int'(running), e.run);
          chk("time_up", int'(time_up), e.tu);
          chk("digit_code", int'(digit_code), e.dc);
          chk("sprite_row", int'(sprite_row), e.row);
          chk("sprite_col", int'(sprite_col), e.col);
        end else begin
          chk("pixel_on", int'(pixel_on), e.pon);
          chk("pixel_color", int'(pixel_color), e.pcol);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs();
    chk("rst_min", int'(min_d), 3);
    chk("rst_tens", int'(tens_d), 0);
    chk("rst_ones", int'(ones_d), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_time_up", int'(time_up), 0);
    chk("rst_digit_code", int'(digit_code), 0);
    chk("rst_row", int'(sprite_row), 0);
    chk("rst_col", int'(sprite_col), 0);
    chk("rst_pixel_on", int'(pixel_on), 0);
    chk("rst_pixel_color", int'(pixel_color), 0);
    chk("rst_z_time_up", int'(z_time_up), 0);
  endtask

  initial begin : stimulus
    #2 Reset_n = 1'b0;
    #20 check_reset_outputs();
    @(posedge Clk); #1 Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Idle cycles: ticks and pauses must not disturb the reload display.
    for (int i = 0; i < 20; i++) step(0, i % 7 == 0, 1'b1, X0 + 5 * i, Y0 + i);

    // Reload 0:00 goes straight to EXPIRED with a single time_up pulse.
    drain();
    zstart = 1'b1;
    @(posedge Clk); #1 zstart = 1'b0;
    chk("zero_time_up", int'(z_time_up), 1);
    chk("zero_running", int'(z_running), 0);
    chk("zero_digits", int'({z_min, z_tens, z_ones}), 0);
    @(posedge Clk); #1;
    chk("zero_time_up_end", int'(z_time_up), 0);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < FPS; i++) step(0, 0, 1, 0, 0);
    run_to(165, 0, 0);

    // Fixed sprite colours at DrawX=X0+33, DrawY=Y0+5 (tens digit cell).
    drain(); spr_mode = 1;
    step(0, 0, 0, X0 + 33, Y0 + 5);
    drain(); spr_mode = 2;
    step(0, 0, 0, X0 + 33, Y0 + 5);
    drain(); spr_mode = 0;

    run_to(150, X0 + 10, Y0 + 2);
    step(0, 1, 0, X0 + 50, Y0 + 7);
    for (int i = 0; i < 200; i++) step(0, 0, 1, X0 + (i % 96), Y0 + (i % 24));
    step(0, 1, 0, X0 + 50, Y0 + 7);
    for (int i = 0; i < FPS; i++) step(0, 0, 1, X0 + 64 + (i % 32), Y0 + 1);

    for (int i = 0; i < 2000; i++)
      step(0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(X0 - 8, X0 + 100)), int'($urandom_range(0, 40)));

    run_to(60, X0 + 70, Y0 + 10);
    run_to(59, X0 + 70, Y0 + 10);

    // Final approach with an opaque sprite so warning blink is visible.
    drain(); spr_mode = 1;
    run_to(0, X0 + 40, Y0 + 3);
    for (int i = 0; i < 20; i++) step(0, i % 5 == 0, 1'b1, X0 + 40, Y0 + 3);
    drain(); spr_mode = 0;

    step(1, 0, 1, 0, 0);
    for (int i = 0; i < FPS + 100; i++) step(0, 0, 1, X0 + (i % 96), Y0 + 4);

    // Mid-countdown reset abandons the run until a new start.
    drain();
    Reset_n = 1'b0;
    #2 check_reset_outputs();
    @(posedge Clk); @(posedge Clk); #1 Reset_n = 1'b1;
    m_secs = RELOAD; m_frame = 0; m_mode = M_IDLE;
    @(posedge Clk); #1;
    for (int i = 0; i < 100; i++)
      step(0, $urandom_range(0, 9) == 0, 1'b1,
           int'($urandom_range(X0 - 8, X0 + 100)), int'($urandom_range(0, 40)));
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < FPS; i++) step(0, 0, 1, X0 + 1, Y0 + 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
